// File: rtl/galetron_hd_pkg.sv
// Shared hard-drive geometry, direction encoding and DMA state encoding
// for the galetron hard-drive subsystem.
package galetron_hd_pkg;

    localparam int HD_DATA_WIDTH        = 32;
    localparam int HD_TRACK_WIDTH       = 7;
    localparam int HD_SECTOR_WIDTH      = 14;
    localparam int HD_NUM_TRACKS        = 3;
    localparam int HD_SECTORS_PER_TRACK = 66;
    localparam int HD_MEM_ADDR_WIDTH    = 10;

    typedef enum logic {
        DIR_LOAD  = 1'b0,   // hard drive -> memory
        DIR_STORE = 1'b1    // memory -> hard drive
    } hd_dir_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FETCH,
        ST_STORE,
        ST_FINISH
    } dma_state_t;

    function automatic logic is_transfer_state(dma_state_t s);
        return s inside {ST_LOAD, ST_FETCH, ST_STORE};
    endfunction

endpackage

// File: rtl/hd_addr_counter.sv
// Loadable track/sector counter. Sector wraps to 0 with a track carry;
// o_overflow flags that the next advance would leave the valid track range.
module hd_addr_counter
    import galetron_hd_pkg::*;
#(
    parameter int TRACK_WIDTH       = HD_TRACK_WIDTH,
    parameter int SECTOR_WIDTH      = HD_SECTOR_WIDTH,
    parameter int NUM_TRACKS        = HD_NUM_TRACKS,
    parameter int SECTORS_PER_TRACK = HD_SECTORS_PER_TRACK
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_load,
    input  logic [TRACK_WIDTH-1:0]  i_track,
    input  logic [SECTOR_WIDTH-1:0] i_sector,
    input  logic                    i_advance,
    output logic [TRACK_WIDTH-1:0]  o_track,
    output logic [SECTOR_WIDTH-1:0] o_sector,
    output logic                    o_overflow
);

    logic [TRACK_WIDTH-1:0]  r_track;
    logic [SECTOR_WIDTH-1:0] r_sector;
    logic                    w_last_sector;

    assign w_last_sector = (r_sector == SECTOR_WIDTH'(SECTORS_PER_TRACK - 1));
    assign o_overflow    = w_last_sector && (r_track >= TRACK_WIDTH'(NUM_TRACKS - 1));
    assign o_track       = r_track;
    assign o_sector      = r_sector;

    // NOTE: non-blocking (<=) in every clocked block so all flops sample pre-edge values.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_track  <= '0;
            r_sector <= '0;
        end else if (i_load) begin
            r_track  <= i_track;
            r_sector <= i_sector;
        end else if (i_advance) begin
            if (w_last_sector) begin
                r_sector <= '0;
                r_track  <= r_track + TRACK_WIDTH'(1);
            end else begin
                r_sector <= r_sector + SECTOR_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/hd_dma_controller.sv
// Block-transfer engine between the harddrive model and data memory:
// one command (direction, track/sector, memory base, length) runs to completion.
module hd_dma_controller
    import galetron_hd_pkg::*;
#(
    parameter int DATA_WIDTH        = HD_DATA_WIDTH,
    parameter int TRACK_WIDTH       = HD_TRACK_WIDTH,
    parameter int SECTOR_WIDTH      = HD_SECTOR_WIDTH,
    parameter int NUM_TRACKS        = HD_NUM_TRACKS,
    parameter int SECTORS_PER_TRACK = HD_SECTORS_PER_TRACK,
    parameter int MEM_ADDR_WIDTH    = HD_MEM_ADDR_WIDTH
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      direction,
    input  logic [TRACK_WIDTH-1:0]    cmd_track,
    input  logic [SECTOR_WIDTH-1:0]   cmd_sector,
    input  logic [MEM_ADDR_WIDTH-1:0] cmd_mem_base,
    input  logic [SECTOR_WIDTH-1:0]   cmd_length,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [TRACK_WIDTH-1:0]    hd_track,
    output logic [SECTOR_WIDTH-1:0]   hd_sector,
    output logic [DATA_WIDTH-1:0]     hd_data_write,
    output logic                      hd_flag_write,
    input  logic [DATA_WIDTH-1:0]     hd_read_data,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_data_write,
    output logic                      mem_write_enable,
    input  logic [DATA_WIDTH-1:0]     mem_read_data
);

    dma_state_t                r_state;
    dma_state_t                w_next_state;
    logic [SECTOR_WIDTH-1:0]   r_remaining;
    logic [MEM_ADDR_WIDTH-1:0] r_mem_addr;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_error;
    logic                      r_hd_flag_write;
    logic                      r_mem_write_enable;

    logic                      w_load;
    logic                      w_advance;
    logic                      w_set_error;
    logic                      w_overflow;
    logic                      w_last_word;
    logic                      w_bad_start;
    logic [TRACK_WIDTH-1:0]    w_track;
    logic [SECTOR_WIDTH-1:0]   w_sector;

    hd_addr_counter #(
        .TRACK_WIDTH       (TRACK_WIDTH),
        .SECTOR_WIDTH      (SECTOR_WIDTH),
        .NUM_TRACKS        (NUM_TRACKS),
        .SECTORS_PER_TRACK (SECTORS_PER_TRACK)
    ) u_addr_counter (
        .i_clock    (clock),
        .i_reset    (reset),
        .i_load     (w_load),
        .i_track    (cmd_track),
        .i_sector   (cmd_sector),
        .i_advance  (w_advance),
        .o_track    (w_track),
        .o_sector   (w_sector),
        .o_overflow (w_overflow)
    );

    assign w_last_word = (r_remaining == SECTOR_WIDTH'(1));
    assign w_bad_start = (cmd_track >= TRACK_WIDTH'(NUM_TRACKS));

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_advance    = 1'b0;
        w_set_error  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                    if (cmd_length == '0) begin
                        w_next_state = ST_FINISH;
                    end else if (w_bad_start) begin
                        w_next_state = ST_FINISH;
                        w_set_error  = 1'b1;
                    end else if (direction == DIR_STORE) begin
                        w_next_state = ST_FETCH;
                    end else begin
                        w_next_state = ST_LOAD;
                    end
                end
            end
            ST_LOAD, ST_STORE: begin
                // A word is committed this cycle; decide what follows it.
                if (w_last_word) begin
                    w_next_state = ST_FINISH;
                end else if (w_overflow) begin
                    w_next_state = ST_FINISH;
                    w_set_error  = 1'b1;
                end else begin
                    w_advance    = 1'b1;
                    w_next_state = (r_state == ST_LOAD) ? ST_LOAD : ST_FETCH;
                end
            end
            ST_FETCH:  w_next_state = ST_STORE;
            ST_FINISH: w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Output flags are registered from the next state so they line up with it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state            <= ST_IDLE;
            r_remaining        <= '0;
            r_mem_addr         <= '0;
            r_busy             <= 1'b0;
            r_done             <= 1'b0;
            r_error            <= 1'b0;
            r_hd_flag_write    <= 1'b0;
            r_mem_write_enable <= 1'b0;
        end else begin
            r_state            <= w_next_state;
            r_busy             <= is_transfer_state(w_next_state);
            r_done             <= (w_next_state == ST_FINISH);
            r_hd_flag_write    <= (w_next_state == ST_STORE);
            r_mem_write_enable <= (w_next_state == ST_LOAD);
            if (w_load || w_set_error) begin
                r_error <= w_set_error;
            end
            if (w_load) begin
                r_remaining <= cmd_length;
                r_mem_addr  <= cmd_mem_base;
            end else if (w_advance) begin
                r_remaining <= r_remaining - SECTOR_WIDTH'(1);
                r_mem_addr  <= r_mem_addr + MEM_ADDR_WIDTH'(1);
            end
        end
    end

    assign busy             = r_busy;
    assign done             = r_done;
    assign error            = r_error;
    assign hd_track         = w_track;
    assign hd_sector        = w_sector;
    assign hd_flag_write    = r_hd_flag_write;
    assign mem_addr         = r_mem_addr;
    assign mem_write_enable = r_mem_write_enable;

    // Read data only arrives in the write cycle, so both data paths pass through, gated by their strobe.
    assign mem_data_write = r_mem_write_enable ? hd_read_data  : '0;
    assign hd_data_write  = r_hd_flag_write    ? mem_read_data : '0;

endmodule
